// File: rtl/serial_monitor.sv
// serial_monitor: decodes an idle-high start/data/parity/stop serial line
// into words and queues good words in a show-ahead FIFO with sticky flags.
module serial_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Din,
    input  logic                        RdEn,
    output logic [DATA_BITS-1:0]        RdData,
    output logic                        Empty,
    output logic                        Full,
    output logic [$clog2(FIFO_DEPTH):0] Count,
    output logic                        FrameErr,
    output logic                        ParityErr,
    output logic                        Overflow,
    input  logic                        ClrErr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sdin_q, sprev_q;
    logic                 fall;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bitc_q, bitc_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 serr_q, serr_d;
    logic                 push_q, push_d;
    logic                 fset_q, fset_d;
    logic                 pset_q, pset_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 do_push, do_pop, drop;

    logic                 ferr_q, ferr_d;
    logic                 perrf_q, perrf_d;
    logic                 ovf_q, ovf_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            sdin_q  <= 1'b1;
            sprev_q <= 1'b1;
        end else begin
            sync1_q <= Din;
            sdin_q  <= sync1_q;
            sprev_q <= sdin_q;
        end
    end

    assign fall = sprev_q & ~sdin_q;

    // Frame decoder state and the one-cycle frame-result pulses
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bitc_q  <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            push_q  <= 1'b0;
            fset_q  <= 1'b0;
            pset_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bitc_q  <= bitc_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            push_q  <= push_d;
            fset_q  <= fset_d;
            pset_q  <= pset_d;
        end
    end

    // Next-state logic: mid-bit sampling, shifting and frame verdict
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TW'(1);
        bitc_d  = bitc_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        push_d  = 1'b0;
        fset_d  = 1'b0;
        pset_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_q == HALF_M1) begin
                    tick_d  = '0;
                    bitc_d  = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                    state_d = sdin_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    shreg_d = {sdin_q, shreg_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ sdin_q;
                    bitc_d  = bitc_q + 4'd1;
                    if (bitc_q == LAST_DATA) begin
                        bitc_d  = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    perr_d  = (par_q ^ sdin_q) != ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d = '0;
                    serr_d = serr_q | ~sdin_q;
                    bitc_d = bitc_q + 4'd1;
                    if (bitc_q == LAST_STOP) begin
                        bitc_d  = '0;
                        state_d = S_IDLE;
                        if (serr_d) begin
                            fset_d = 1'b1;
                        end else if (perr_q) begin
                            pset_d = 1'b1;
                        end else begin
                            push_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Empty   = (cnt_q == '0);
    assign Full    = (cnt_q == DEPTH);
    assign do_pop  = RdEn & ~Empty;
    assign do_push = push_q & (~Full | do_pop);
    assign drop    = push_q & ~do_push;

    // FIFO pointer and occupancy update
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Word storage; the shift register still holds the word one cycle on
    always_ff @(posedge Clock) begin
        if (Reset && do_push) begin
            mem_q[wptr_q] <= shreg_q;
        end
    end

    // Sticky flags: a new error wins over a simultaneous clear
    always_comb begin
        ferr_d  = (ferr_q & ~ClrErr) | fset_q;
        perrf_d = (perrf_q & ~ClrErr) | pset_q;
        ovf_d   = (ovf_q & ~ClrErr) | drop;
    end

    // Sticky flag registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ferr_q  <= 1'b0;
            perrf_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ferr_q  <= ferr_d;
            perrf_q <= perrf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign RdData    = Empty ? '0 : mem_q[rptr_q];
    assign Count     = cnt_q;
    assign FrameErr  = ferr_q;
    assign ParityErr = perrf_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor: an 8N1/depth-8 and an 8E2/depth-4 monitor checked
// every cycle against a frame-level list model of the word buffer.
module tb_serial_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       din_a, din_b, rd_a, rd_b, clr_a, clr_b;
    logic [7:0] rdata_a, rdata_b;
    logic       empty_a, empty_b, full_a, full_b;
    logic [3:0] count_a;
    logic [2:0] count_b;
    logic       frame_a, frame_b, parity_a, parity_b, ovf_a, ovf_b;

    serial_monitor #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(8)
    ) dut_a (
        .Clock(clk), .Reset(rst_n), .Din(din_a), .RdEn(rd_a),
        .RdData(rdata_a), .Empty(empty_a), .Full(full_a),
        .Count(count_a), .FrameErr(frame_a), .ParityErr(parity_a),
        .Overflow(ovf_a), .ClrErr(clr_a)
    );

    serial_monitor #(
        .CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .Clock(clk), .Reset(rst_n), .Din(din_b), .RdEn(rd_b),
        .RdData(rdata_b), .Empty(empty_b), .Full(full_b),
        .Count(count_b), .FrameErr(frame_b), .ParityErr(parity_b),
        .Overflow(ovf_b), .ClrErr(clr_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 1'b0;

    logic [7:0] mw [2][16];
    int         msize [2] = '{0, 0};
    bit         mfe [2] = '{0, 0};
    bit         mpe [2] = '{0, 0};
    bit         mov [2] = '{0, 0};
    int         ev_t [2] = '{0, 0};
    int         ev_kind [2] = '{0, 0};
    logic [7:0] ev_word [2];

    function automatic int cpb(input int d);
        return (d == 0) ? 16 : 8;
    endfunction
    function automatic int nbits(input int d);
        return (d == 0) ? 10 : 12;
    endfunction
    function automatic int nstops(input int d);
        return (d == 0) ? 1 : 2;
    endfunction
    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int d);
        bit rd, clr, nfe, npe, nov;
        rd  = (d == 0) ? rd_a : rd_b;
        clr = (d == 0) ? clr_a : clr_b;
        if (!rst_n) begin
            msize[d] = 0;
            mfe[d]   = 0;
            mpe[d]   = 0;
            mov[d]   = 0;
            ev_t[d]  = 0;
            return;
        end
        if (rd && msize[d] > 0) begin
            for (int i = 0; i < 15; i++) mw[d][i] = mw[d][i+1];
            msize[d]--;
        end
        nfe = 0;
        npe = 0;
        nov = 0;
        if (ev_t[d] == cyc) begin
            ev_t[d] = 0;
            if (ev_kind[d] == 1) nfe = 1;
            else if (ev_kind[d] == 2) npe = 1;
            else if (msize[d] < depth_of(d)) begin
                mw[d][msize[d]] = ev_word[d];
                msize[d]++;
            end else nov = 1;
        end
        mfe[d] = (mfe[d] && !clr) || nfe;
        mpe[d] = (mpe[d] && !clr) || npe;
        mov[d] = (mov[d] && !clr) || nov;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0);
        model_step(1);
    end

    task automatic check_dut(input int d);
        logic [31:0] er;
        er = (msize[d] > 0) ? 32'(mw[d][0]) : 32'd0;
        if (d == 0) begin
            cmp("a.RdData", rdata_a, er);
            cmp("a.Count", count_a, msize[0]);
            cmp("a.Empty", empty_a, msize[0] == 0);
            cmp("a.Full", full_a, msize[0] == 8);
            cmp("a.FrameErr", frame_a, mfe[0]);
            cmp("a.ParityErr", parity_a, mpe[0]);
            cmp("a.Overflow", ovf_a, mov[0]);
        end else begin
            cmp("b.RdData", rdata_b, er);
            cmp("b.Count", count_b, msize[1]);
            cmp("b.Empty", empty_b, msize[1] == 0);
            cmp("b.Full", full_b, msize[1] == 4);
            cmp("b.FrameErr", frame_b, mfe[1]);
            cmp("b.ParityErr", parity_b, mpe[1]);
            cmp("b.Overflow", ovf_b, mov[1]);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_dut(0);
            check_dut(1);
        end
    end

    // Called at a negedge; the next posedge is the frame's t0.
    task automatic send(input int d, input logic [7:0] w, input bit badpar,
                        input int badstop, input int cut);
        logic [15:0] b;
        int n, c, nb, ns;
        c  = cpb(d);
        n  = nbits(d);
        ns = nstops(d);
        b  = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = w[i];
        if (d == 1) b[9] = (^w) ^ badpar;
        for (int s = 0; s < ns; s++) b[n-ns+s] = (badstop == s + 1) ? 1'b0 : 1'b1;
        nb = (cut == 0) ? n : cut;
        if (cut == 0) begin
            ev_word[d] = w;
            ev_kind[d] = (badstop != 0) ? 1 : (badpar ? 2 : 0);
            ev_t[d]    = cyc + 1 + 3 + c / 2 + (n - 1) * c;
        end
        for (int i = 0; i < nb; i++) begin
            if (d == 0) din_a = b[i];
            else        din_b = b[i];
            repeat (c) @(negedge clk);
        end
        if (d == 0) din_a = 1'b1;
        else        din_b = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rd(input int d);
        if (d == 0) rd_a = 1'b1; else rd_b = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        if (d == 0) clr_a = 1'b1; else clr_b = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int  t0;
    int  rstart;
    bit  done_a, done_b;

    initial begin
        din_a = 1; din_b = 1; rd_a = 0; rd_b = 0;
        clr_a = 0; clr_b = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        checking = 1;
        cmp("rst_empty", empty_a, 1);
        cmp("rst_count", count_a, 0);
        cmp("rst_rdata", rdata_a, 0);
        cmp("rst_full_b", full_b, 0);
        idle(5);

        // 0xA5 in 8N1: visible exactly at t0+155
        t0 = cyc + 1;
        fork
            send(0, 8'hA5, 0, 0, 0);
            begin
                while (cyc < t0 + 154) @(negedge clk);
                cmp("a5_early_count", count_a, 0);
                @(negedge clk);
                cmp("a5_rdata", rdata_a, 8'hA5);
                cmp("a5_count", count_a, 1);
            end
        join
        idle(10);
        pulse_rd(0);
        cmp("pop_empty", empty_a, 1);
        cmp("pop_rdata", rdata_a, 0);

        // 3-cycle low glitch, then a real frame starting at t0+12
        t0 = cyc + 1;
        din_a = 0;
        idle(3);
        din_a = 1;
        while (cyc < t0 + 11) @(negedge clk);
        cmp("glitch_count", count_a, 0);
        send(0, 8'h3C, 0, 0, 0);
        idle(2);
        cmp("after_glitch_data", rdata_a, 8'h3C);
        cmp("after_glitch_ferr", frame_a, 0);
        pulse_rd(0);

        // stop bit low, then a good frame
        send(0, 8'h5A, 0, 1, 0);
        idle(2);
        cmp("ferr_set", frame_a, 1);
        cmp("ferr_nopush", count_a, 0);
        send(0, 8'h11, 0, 0, 0);
        idle(4);
        cmp("ferr_next_data", rdata_a, 8'h11);
        cmp("ferr_next_count", count_a, 1);
        pulse_rd(0);

        // even parity on dut_b
        send(1, 8'h03, 1, 0, 0);
        idle(1);
        cmp("perr_set", parity_b, 1);
        cmp("perr_count", count_b, 0);
        pulse_clr(1);
        cmp("perr_clr", parity_b, 0);
        send(1, 8'h03, 0, 0, 0);
        idle(2);
        cmp("par_ok_count", count_b, 1);
        cmp("par_ok_data", rdata_b, 8'h03);
        pulse_rd(1);

        // overflow with depth 4, back-to-back frames
        for (int k = 1; k <= 5; k++) send(1, 8'(k), 0, 0, 0);
        idle(2);
        cmp("ovf_full", full_b, 1);
        cmp("ovf_count", count_b, 4);
        cmp("ovf_flag", ovf_b, 1);
        for (int k = 1; k <= 4; k++) begin
            cmp("ovf_order", rdata_b, k);
            pulse_rd(1);
        end
        cmp("ovf_drained", empty_b, 1);
        pulse_clr(1);
        cmp("ovf_clr", ovf_b, 0);

        // same again with a pop on the 5th push cycle
        t0 = cyc + 1;
        fork
            for (int k = 1; k <= 5; k++) send(1, 8'(k), 0, 0, 0);
            begin
                while (cyc < t0 + 4 * 96 + 94) @(negedge clk);
                rd_b = 1;
                @(negedge clk);
                rd_b = 0;
            end
        join
        idle(2);
        cmp("nofl_flag", ovf_b, 0);
        cmp("nofl_count", count_b, 4);
        for (int k = 2; k <= 4; k++) begin
            cmp("nofl_order", rdata_b, k);
            pulse_rd(1);
        end
        cmp("nofl_last", rdata_b, 8'h05);

        // reset in the middle of the data bits
        cmp("pre_rst_ferr", frame_a, 1);
        send(0, 8'h7E, 0, 0, 5);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        cmp("mid_rst_ferr", frame_a, 0);
        cmp("mid_rst_count_b", count_b, 0);
        cmp("mid_rst_empty_b", empty_b, 1);
        cmp("mid_rst_rdata_b", rdata_b, 0);
        idle(20);
        cmp("mid_rst_nopush", count_a, 0);
        send(0, 8'h7E, 0, 0, 0);
        idle(3);
        cmp("post_rst_data", rdata_a, 8'h7E);
        cmp("post_rst_count", count_a, 1);
        pulse_rd(0);

        // randomized traffic on both lines
        rstart = cyc;
        done_a = 0;
        done_b = 0;
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    int bs, gap;
                    bs  = ($urandom % 8 == 0) ? 1 : 0;
                    send(0, 8'($urandom), 0, bs, 0);
                    gap = $urandom_range(0, 12);
                    if (bs != 0 && gap == 0) gap = 1;
                    idle(gap);
                end
                done_a = 1;
            end
            begin
                for (int f = 0; f < 40; f++) begin
                    int bs, gap;
                    bit bp;
                    bp  = ($urandom % 6 == 0);
                    bs  = ($urandom % 8 == 0) ? $urandom_range(1, 2) : 0;
                    send(1, 8'($urandom), bp, bs, 0);
                    gap = $urandom_range(0, 12);
                    if (bs == 2 && gap == 0) gap = 1;
                    idle(gap);
                end
                done_b = 1;
            end
            begin
                while (!(done_a && done_b)) begin
                    int p;
                    p = (cyc < rstart + 3000) ? 4 : 35;
                    rd_a  = ($urandom % 100) < p;
                    rd_b  = ($urandom % 100) < p;
                    clr_a = ($urandom % 100) < 3;
                    clr_b = ($urandom % 100) < 3;
                    @(negedge clk);
                end
                rd_a = 0; rd_b = 0; clr_a = 0; clr_b = 0;
            end
        join
        idle(20);
        rd_a = 1;
        rd_b = 1;
        idle(10);
        rd_a = 0;
        rd_b = 0;
        idle(5);
        cmp("final_empty_a", empty_a, 1);
        cmp("final_empty_b", empty_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
